arbitro_memoria_datos: RTL and testbench

ARBITRO_MEMORIA_DATOS -- requirements
Module: arbitro_memoria_datos

---
 rtl/arbitro_memoria_datos.sv | 146 ++++++++++++++
 tb/tb_arbitro_memoria_datos.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria_datos.sv
// Round-robin arbiter giving two requesters access to a single-port data memory,
// one transaction every three cycles. Optional address check: ARBITRO_VERIFICA_DIR_EN.
module arbitro_memoria_datos #(
   parameter int Ancho_Dato      = 32,
   parameter int Ancho_Direccion = 32,
   parameter int Tamanio_Mem     = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sol_0,
   input  logic                       sol_1,
   input  logic                       esc_0,
   input  logic                       esc_1,
   input  logic [Ancho_Direccion-1:0] dir_0,
   input  logic [Ancho_Direccion-1:0] dir_1,
   input  logic [Ancho_Dato-1:0]      dato_esc_0,
   input  logic [Ancho_Dato-1:0]      dato_esc_1,
   output logic                       listo_0,
   output logic                       listo_1,
   output logic                       error_0,
   output logic                       error_1,
   output logic [Ancho_Dato-1:0]      dato_lec,
   output logic                       ocupado,
   output logic                       mem_escritura_habilitada,
   output logic                       mem_lectura_habilitada,
   output logic [Ancho_Direccion-1:0] mem_direccion,
   output logic [Ancho_Dato-1:0]      mem_dato_escritura,
   input  logic [Ancho_Dato-1:0]      mem_dato_lectura
);

   typedef enum logic [1:0] {
      REPOSO    = 2'd0,
      ACCESO    = 2'd1,
      RESPUESTA = 2'd2
   } estado_t;

   estado_t estado, estado_sig;

   logic                       prioridad;
   logic                       ganador;
   logic                       ganador_sig;
   logic                       hay_solicitud;
   logic                       esc_lat;
   logic [Ancho_Direccion-1:0] dir_lat;
   logic [Ancho_Dato-1:0]      dato_lat;
   logic                       esc_sel;
   logic [Ancho_Direccion-1:0] dir_sel;
   logic [Ancho_Dato-1:0]      dato_sel;
   logic                       rechazo;
   logic                       acceso_valido;

   assign hay_solicitud = sol_0 | sol_1;

   // A lone requester always wins; contention is settled by the priority pointer.
   always_comb begin
      ganador_sig = 1'b0;
      if (sol_0 && sol_1)
         ganador_sig = prioridad;
      else if (sol_1)
         ganador_sig = 1'b1;
   end

   always_comb begin
      esc_sel  = ganador_sig ? esc_1      : esc_0;
      dir_sel  = ganador_sig ? dir_1      : dir_0;
      dato_sel = ganador_sig ? dato_esc_1 : dato_esc_0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         estado <= REPOSO;
      else
         estado <= estado_sig;
   end

   always_comb begin
      estado_sig = estado;
      case (estado)
         REPOSO:    if (hay_solicitud) estado_sig = ACCESO;
         ACCESO:    estado_sig = RESPUESTA;
         RESPUESTA: estado_sig = REPOSO;
         default:   estado_sig = REPOSO;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ganador  <= 1'b0;
         esc_lat  <= 1'b0;
         dir_lat  <= '0;
         dato_lat <= '0;
      end else if (estado == REPOSO && hay_solicitud) begin
         ganador  <= ganador_sig;
         esc_lat  <= esc_sel;
         dir_lat  <= dir_sel;
         dato_lat <= dato_sel;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prioridad <= 1'b0;
      else if (estado == RESPUESTA)
         prioridad <= ~ganador;
   end

`ifdef ARBITRO_VERIFICA_DIR_EN
   localparam logic [Ancho_Direccion-1:0] LIMITE = Ancho_Direccion'(Tamanio_Mem);

   logic [Ancho_Direccion-1:0] indice_sel;
   logic                       dir_invalida;

   assign indice_sel   = {2'b00, dir_sel[Ancho_Direccion-1:2]};
   assign dir_invalida = (dir_sel[1:0] != 2'b00) || (indice_sel >= LIMITE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rechazo <= 1'b0;
      else if (estado == REPOSO && hay_solicitud)
         rechazo <= dir_invalida;
   end
`else
   assign rechazo = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         dato_lec <= '0;
      else if (acceso_valido && !esc_lat)
         dato_lec <= mem_dato_lectura;
   end

   // Enables decode straight from the state register, so reset kills them at once.
   assign acceso_valido            = (estado == ACCESO) && !rechazo;
   assign mem_escritura_habilitada = acceso_valido && esc_lat;
   assign mem_lectura_habilitada   = acceso_valido && !esc_lat;
   assign mem_direccion            = (estado == ACCESO) ? dir_lat : '0;
   assign mem_dato_escritura       = (estado == ACCESO) ? dato_lat : '0;

   assign ocupado = (estado != REPOSO);
   assign listo_0 = (estado == RESPUESTA) && !ganador;
   assign listo_1 = (estado == RESPUESTA) && ganador;
   assign error_0 = listo_0 && rechazo;
   assign error_1 = listo_1 && rechazo;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Directed bench for arbitro_memoria_datos: table of whole transactions plus
// hand-written sequences for round-robin alternation and reset during ACCESO.
module tb_arbitro_memoria_datos;

`ifdef ARBITRO_VERIFICA_DIR_EN
   localparam bit VERIF = 1'b1;
`else
   localparam bit VERIF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        sol_0, sol_1, esc_0, esc_1;
   logic [31:0] dir_0, dir_1, dato_esc_0, dato_esc_1;
   logic        listo_0, listo_1, error_0, error_1;
   logic [31:0] dato_lec;
   logic        ocupado;
   logic        mem_escritura_habilitada, mem_lectura_habilitada;
   logic [31:0] mem_direccion, mem_dato_escritura, mem_dato_lectura;

   logic [31:0] mem [0:1023];

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rd;

   always #5 clk = ~clk;

   arbitro_memoria_datos #(
      .Ancho_Dato(32),
      .Ancho_Direccion(32),
      .Tamanio_Mem(256)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sol_0(sol_0),
      .sol_1(sol_1),
      .esc_0(esc_0),
      .esc_1(esc_1),
      .dir_0(dir_0),
      .dir_1(dir_1),
      .dato_esc_0(dato_esc_0),
      .dato_esc_1(dato_esc_1),
      .listo_0(listo_0),
      .listo_1(listo_1),
      .error_0(error_0),
      .error_1(error_1),
      .dato_lec(dato_lec),
      .ocupado(ocupado),
      .mem_escritura_habilitada(mem_escritura_habilitada),
      .mem_lectura_habilitada(mem_lectura_habilitada),
      .mem_direccion(mem_direccion),
      .mem_dato_escritura(mem_dato_escritura),
      .mem_dato_lectura(mem_dato_lectura)
   );

   // Memory large enough that out-of-range addresses never alias valid words.
   always @(posedge clk)
      if (mem_escritura_habilitada)
         mem[mem_direccion[11:2]] <= mem_dato_escritura;
   assign mem_dato_lectura = mem[mem_direccion[11:2]];

   typedef struct packed {
      bit          s0;
      bit          s1;
      bit          e0;
      bit          e1;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] d0;
      logic [31:0] d1;
      bit          win;
      bit          inval;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string nombre, input logic [31:0] actual,
                        input logic [31:0] esperado);
      checks++;
      if (actual !== esperado) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nombre, actual, esperado);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sol_0 = 1'b0;
      sol_1 = 1'b0;
      #1;
      check("rst_ocupado", {31'd0, ocupado}, 32'd0);
      check("rst_listo", {30'd0, listo_1, listo_0}, 32'd0);
      check("rst_error", {30'd0, error_1, error_0}, 32'd0);
      check("rst_en", {30'd0, mem_escritura_habilitada, mem_lectura_habilitada}, 32'd0);
      check("rst_dato_lec", dato_lec, 32'd0);
      check("rst_mem_dir", mem_direccion, 32'd0);
      check("rst_mem_dat", mem_dato_escritura, 32'd0);
      last_rd = 32'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Entered and left at a negedge with the arbiter idle.
   task automatic do_txn(input vec_t v, input int n);
      logic        wesc;
      logic [31:0] wdir, wdat;
      bit          rej;
      wesc = v.win ? v.e1 : v.e0;
      wdir = v.win ? v.a1 : v.a0;
      wdat = v.win ? v.d1 : v.d0;
      rej  = v.inval && VERIF;
      sol_0 = v.s0; sol_1 = v.s1; esc_0 = v.e0; esc_1 = v.e1;
      dir_0 = v.a0; dir_1 = v.a1; dato_esc_0 = v.d0; dato_esc_1 = v.d1;
      @(negedge clk);
      check($sformatf("v%0d_ocupado_acc", n), {31'd0, ocupado}, 32'd1);
      check($sformatf("v%0d_wr_en", n), {31'd0, mem_escritura_habilitada}, {31'd0, wesc && !rej});
      check($sformatf("v%0d_rd_en", n), {31'd0, mem_lectura_habilitada}, {31'd0, !wesc && !rej});
      check($sformatf("v%0d_mem_dir", n), mem_direccion, wdir);
      if (wesc)
         check($sformatf("v%0d_mem_dat", n), mem_dato_escritura, wdat);
      check($sformatf("v%0d_listo_acc", n), {30'd0, listo_1, listo_0}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_listo_0", n), {31'd0, listo_0}, {31'd0, !v.win});
      check($sformatf("v%0d_listo_1", n), {31'd0, listo_1}, {31'd0, v.win});
      check($sformatf("v%0d_error_0", n), {31'd0, error_0}, {31'd0, rej && !v.win});
      check($sformatf("v%0d_error_1", n), {31'd0, error_1}, {31'd0, rej && v.win});
      if (!wesc && !rej)
         last_rd = v.exp;
      check($sformatf("v%0d_dato_lec", n), dato_lec, last_rd);
      sol_0 = 1'b0;
      sol_1 = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_ocupado_fin", n), {31'd0, ocupado}, 32'd0);
      check($sformatf("v%0d_listo_fin", n), {30'd0, listo_1, listo_0}, 32'd0);
   endtask

   vec_t tabla [10];

   initial begin
      rst = 1'b1;
      sol_0 = 1'b0; sol_1 = 1'b0; esc_0 = 1'b0; esc_1 = 1'b0;
      dir_0 = '0; dir_1 = '0; dato_esc_0 = '0; dato_esc_1 = '0;
      last_rd = '0;

      //           s0 s1 e0 e1  a0            a1            d0            d1            win inv exp
      tabla[0] = '{1, 0, 1, 0, 32'h0000_0004, 32'h0,        32'hCAFE_BABE, 32'h0,        0, 0, 32'h0};
      tabla[1] = '{0, 1, 0, 0, 32'h0,        32'h0000_0004, 32'h0,        32'h0,        1, 0, 32'hCAFE_BABE};
      tabla[2] = '{1, 0, 1, 0, 32'h0000_0000, 32'h0,        32'hDEAD_BEEF, 32'h0,        0, 0, 32'h0};
      tabla[3] = '{0, 1, 0, 0, 32'h0,        32'h0000_0000, 32'h0,        32'h0,        1, 0, 32'hDEAD_BEEF};
      tabla[4] = '{0, 1, 0, 1, 32'h0,        32'h0000_03FC, 32'h0,        32'hABCD_EF01, 1, 0, 32'h0};
      tabla[5] = '{1, 1, 0, 1, 32'h0000_03FC, 32'h0000_0008, 32'h0,        32'h1111_2222, 0, 0, 32'hABCD_EF01};
      tabla[6] = '{1, 1, 1, 0, 32'h0000_0008, 32'h0000_0004, 32'h0000_0055, 32'h0,        1, 0, 32'hCAFE_BABE};
      tabla[7] = '{1, 0, 1, 0, 32'h0000_0400, 32'h0,        32'h0000_0099, 32'h0,        0, 1, 32'h0};
      tabla[8] = '{0, 1, 0, 1, 32'h0,        32'h0000_0002, 32'h0,        32'h0000_0077, 1, 1, 32'h0};
      tabla[9] = '{0, 1, 0, 0, 32'h0,        32'h0000_03FC, 32'h0,        32'h0,        1, 0, 32'hABCD_EF01};

      do_reset();

      // Both requesters hold their request: 0, then 1, then 0 again, three cycles apart.
      sol_0 = 1'b1; sol_1 = 1'b1; esc_0 = 1'b0; esc_1 = 1'b0;
      dir_0 = 32'h4; dir_1 = 32'h8;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         check($sformatf("rr%0d_listo_0", k), {31'd0, listo_0}, {31'd0, (k == 2 || k == 8)});
         check($sformatf("rr%0d_listo_1", k), {31'd0, listo_1}, {31'd0, (k == 5)});
         check($sformatf("rr%0d_ocupado", k), {31'd0, ocupado}, {31'd0, (k % 3 != 0)});
      end
      sol_0 = 1'b0; sol_1 = 1'b0;

      do_reset();
      for (int i = 0; i < 10; i++)
         do_txn(tabla[i], i);

      // Reset lands in the middle of a write; the old word at 0x10 must survive.
      do_txn('{1, 0, 1, 0, 32'h10, 32'h0, 32'hA5A5_A5A5, 32'h0, 0, 0, 32'h0}, 20);
      sol_0 = 1'b1; esc_0 = 1'b1; dir_0 = 32'h10; dato_esc_0 = 32'h1234_5678;
      @(negedge clk);
      check("rstacc_wr_en_before", {31'd0, mem_escritura_habilitada}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("rstacc_wr_en_after", {31'd0, mem_escritura_habilitada}, 32'd0);
      check("rstacc_ocupado", {31'd0, ocupado}, 32'd0);
      sol_0 = 1'b0;
      last_rd = 32'd0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("rstacc_no_listo%0d", k), {30'd0, listo_1, listo_0}, 32'd0);
      end
      do_txn('{1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 0, 32'hA5A5_A5A5}, 21);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
